control_unit: RTL and testbench

Multi-cycle sequencer for the RV32I core. It decodes the fetched instruction and steps an FSM through FETCH, DECODE, EXECUTE, memory and writeback phases. In each state it drives the datapath's select, enable and ALU-op inputs and the data-bus handshake. It sits directly upstream of the datapath and sources every one of its control-side ports.

---
 rtl/cu_pkg.sv | 51 +++++
 rtl/cu_decoder.sv | 69 ++++++
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
// The HALT state exists only when CU_ILLEGAL_TRAP_EN is defined.
package cu_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [2:0] RFWD_ALU   = 3'd0;
    localparam logic [2:0] RFWD_LOAD  = 3'd1;
    localparam logic [2:0] RFWD_IMM   = 3'd2;
    localparam logic [2:0] RFWD_AUIPC = 3'd3;
    localparam logic [2:0] RFWD_PC4   = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM_S,
        S_MEM_L,
        S_WB_L
`ifdef CU_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_L, C_S, C_B, C_LU, C_AU, C_J, C_JL, C_ILL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu;
        logic       alu_src;
        logic [2:0] rfwd;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/cu_decoder.sv
// Pure combinational instruction decode: class plus datapath selects.
import cu_pkg::*;

module cu_decoder (
    input  logic [31:0] instrCode,
    output dec_t        dec
);

    logic [2:0] funct3;
    logic       unused_bits;

    assign funct3      = instrCode[14:12];
    assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    always_comb begin
        dec       = '0;
        dec.cls   = C_ILL;
        dec.alu   = ALU_ADD;
        dec.rfwd  = RFWD_ALU;
        dec.legal = 1'b1;
        case (instrCode[6:0])
            OP_R: begin
                dec.cls = C_R;
                dec.alu = {instrCode[30], funct3};
            end
            OP_I: begin
                // bit 30 is an immediate bit except for the shift-right pair
                dec.cls     = C_I;
                dec.alu     = {(funct3 == 3'b101) & instrCode[30], funct3};
                dec.alu_src = 1'b1;
            end
            OP_L: begin
                dec.cls     = C_L;
                dec.alu_src = 1'b1;
                dec.rfwd    = RFWD_LOAD;
            end
            OP_S: begin
                dec.cls     = C_S;
                dec.alu_src = 1'b1;
            end
            OP_B: begin
                dec.cls    = C_B;
                dec.alu    = {1'b0, funct3};
                dec.branch = 1'b1;
            end
            OP_LU: begin
                dec.cls  = C_LU;
                dec.rfwd = RFWD_IMM;
            end
            OP_AU: begin
                dec.cls  = C_AU;
                dec.rfwd = RFWD_AUIPC;
            end
            OP_J: begin
                dec.cls  = C_J;
                dec.jal  = 1'b1;
                dec.rfwd = RFWD_PC4;
            end
            OP_JL: begin
                dec.cls  = C_JL;
                dec.jal  = 1'b1;
                dec.jalr = 1'b1;
                dec.rfwd = RFWD_PC4;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I sequencer: FSM plus state-gated decode outputs.
// Define CU_ILLEGAL_TRAP_EN to trap unrecognised opcodes into HALT.
import cu_pkg::*;

module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        PCEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        busWe,
    output logic        busRe,
    output logic        illegalInstr
);

    state_t state;
    dec_t   dec;
    logic   is_mem;

    cu_decoder u_dec (
        .instrCode (instrCode),
        .dec       (dec)
    );

    assign is_mem = (dec.cls == C_S) || (dec.cls == C_L);

`ifdef CU_ILLEGAL_TRAP_EN
    logic ill_q;
    assign illegalInstr = ill_q;
`else
    assign illegalInstr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
`ifdef CU_ILLEGAL_TRAP_EN
            ill_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
`ifdef CU_ILLEGAL_TRAP_EN
                S_DECODE: begin
                    if (!dec.legal) begin
                        state <= S_HALT;
                        ill_q <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_HALT:   state <= S_HALT;
`else
                S_DECODE: state <= S_EXECUTE;
`endif
                S_EXECUTE: begin
                    if (dec.cls == C_S)      state <= S_MEM_S;
                    else if (dec.cls == C_L) state <= S_MEM_L;
                    else                     state <= S_FETCH;
                end
                S_MEM_S:  if (busReady) state <= S_FETCH;
                S_MEM_L:  if (busReady) state <= S_WB_L;
                S_WB_L:   state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Decode fields are visible from DECODE to the final state; enables are per-state.
    always_comb begin
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = 4'b0000;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 3'd0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        busWe         = 1'b0;
        busRe         = 1'b0;
        if (state inside {S_DECODE, S_EXECUTE, S_MEM_S, S_MEM_L, S_WB_L}) begin
            aluControl    = dec.alu;
            aluSrcMuxSel  = dec.alu_src;
            RFWDSrcMuxSel = dec.rfwd;
            branch        = dec.branch;
            jal           = dec.jal;
            jalr          = dec.jalr;
        end
        case (state)
            S_EXECUTE: begin
                PCEn      = !is_mem;
                regFileWe = !is_mem && dec.legal && (dec.cls != C_B);
            end
            S_MEM_S: begin
                busWe = 1'b1;
                PCEn  = busReady;
            end
            S_MEM_L: busRe = 1'b1;
            S_WB_L: begin
                PCEn      = 1'b1;
                regFileWe = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction expected traces built from the ISA rules.
module tb_control_unit;

    typedef struct packed {
        logic       pc_en;
        logic       rf_we;
        logic [3:0] alu;
        logic       src;
        logic [2:0] rfwd;
        logic       br;
        logic       jal;
        logic       jalr;
        logic       bwe;
        logic       bre;
        logic       ill;
    } exp_t;

    localparam int K_ALU = 0, K_BR = 1, K_ST = 2, K_LD = 3, K_ILL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busWe, busRe, illegalInstr;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;

    int   checks = 0;
    int   errors = 0;
    exp_t ex;
    bit   ex_valid = 1'b0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .busReady      (busReady),
        .PCEn          (PCEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .busWe         (busWe),
        .busRe         (busRe),
        .illegalInstr  (illegalInstr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ex_valid) begin
            chk("PCEn",          32'(PCEn),          32'(ex.pc_en));
            chk("regFileWe",     32'(regFileWe),     32'(ex.rf_we));
            chk("aluControl",    32'(aluControl),    32'(ex.alu));
            chk("aluSrcMuxSel",  32'(aluSrcMuxSel),  32'(ex.src));
            chk("RFWDSrcMuxSel", 32'(RFWDSrcMuxSel), 32'(ex.rfwd));
            chk("branch",        32'(branch),        32'(ex.br));
            chk("jal",           32'(jal),           32'(ex.jal));
            chk("jalr",          32'(jalr),          32'(ex.jalr));
            chk("busWe",         32'(busWe),         32'(ex.bwe));
            chk("busRe",         32'(busRe),         32'(ex.bre));
            chk("illegalInstr",  32'(illegalInstr),  32'(ex.ill));
        end
    end

    // Decode fields straight from the RV32I opcode table; no enables.
    function automatic exp_t model_dec(input logic [31:0] i, output int kind);
        exp_t       e;
        logic [2:0] f3;
        e    = '0;
        f3   = i[14:12];
        kind = K_ALU;
        case (i[6:0])
            7'h33: e.alu = {i[30], f3};
            7'h13: begin e.alu = {(f3 == 3'd5) & i[30], f3}; e.src = 1'b1; end
            7'h03: begin e.src = 1'b1; e.rfwd = 3'd1; kind = K_LD; end
            7'h23: begin e.src = 1'b1; kind = K_ST; end
            7'h63: begin e.alu = {1'b0, f3}; e.br = 1'b1; kind = K_BR; end
            7'h37: e.rfwd = 3'd2;
            7'h17: e.rfwd = 3'd3;
            7'h6F: begin e.jal = 1'b1; e.rfwd = 3'd4; end
            7'h67: begin e.jal = 1'b1; e.jalr = 1'b1; e.rfwd = 3'd4; end
            default: kind = K_ILL;
        endcase
        return e;
    endfunction

    // Starts just after the edge into FETCH; w = busReady-low cycles in the memory phase;
    // rst_at = cycle index in which reset is pulled low (-1 = none).
    task automatic run(input logic [31:0] i, input int w, input int rst_at,
                       input int lit_alu, input int lit_len);
        exp_t d, e;
        int   kind, len;
        d   = model_dec(i, kind);
        len = (kind == K_ST) ? 4 + w : (kind == K_LD) ? 5 + w : 3;
        if (lit_len > 0) chk("length", 32'(len), 32'(lit_len));
        instrCode = i;
        for (int c = 0; c < len; c++) begin
            e        = (c > 0) ? d : '0;
            busReady = 1'b1;
            if ((kind == K_ST || kind == K_LD) && c >= 3 && c <= 3 + w) begin
                busReady = (c == 3 + w);
                if (kind == K_ST) begin
                    e.bwe   = 1'b1;
                    e.pc_en = (c == 3 + w);
                end else begin
                    e.bre = 1'b1;
                end
            end
            if (kind == K_LD && c == 4 + w) begin
                e.pc_en = 1'b1;
                e.rf_we = 1'b1;
            end
            if (kind != K_ST && kind != K_LD && c == 2) begin
                e.pc_en = 1'b1;
                e.rf_we = (kind == K_ALU);
            end
            ex       = e;
            ex_valid = 1'b1;
            if (c == rst_at) reset = 1'b0;
            if (c == 1 && lit_alu >= 0) begin
                #2;
                chk("lit_aluControl", 32'(aluControl), 32'(lit_alu));
            end
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_busRe", 32'(busRe), 32'd0);
                chk("rst_PCEn",  32'(PCEn),  32'd0);
                break;
            end
        end
    endtask

`ifdef CU_ILLEGAL_TRAP_EN
    task automatic run_halt();
        exp_t e;
        instrCode = 32'h0000007F;
        busReady  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            e     = '0;
            e.ill = (c >= 2);
            ex    = e;
            if (c == 6) reset = 1'b0;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("halt_cleared", 32'(illegalInstr), 32'd0);
    endtask
`endif

    initial begin
        reset     = 1'b0;
        busReady  = 1'b0;
        instrCode = 32'h002081B3;
        @(posedge clk);
        #1;
        ex       = '0;
        ex_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;

        run(32'h002081B3, 0, -1, 4'h0, 3);  // add
        run(32'h402081B3, 0, -1, 4'h8, 3);  // sub
        run(32'h4030D293, 0, -1, 4'hD, 3);  // srai
        run(32'h0030D293, 0, -1, 4'h5, 3);  // srli
        run(32'h4000F293, 0, -1, 4'h7, 3);  // andi, bit30 is immediate
        run(32'h0080A283, 2, -1, 4'h0, 7);  // lw, two wait cycles
        run(32'h0020A223, 0, -1, 4'h0, 4);  // sw
        run(32'h0020A223, 3, -1, -1,   7);  // sw, three wait cycles
        run(32'h00209463, 0, -1, 4'h1, 3);  // bne
        run(32'h000280E7, 0, -1, 4'h0, 3);  // jalr
        run(32'h010000EF, 0, -1, 4'h0, 3);  // jal
        run(32'h123453B7, 0, -1, 4'h0, 3);  // lui
        run(32'h00001517, 0, -1, 4'h0, 3);  // auipc
        run(32'h0080A283, 0, -1, -1,   5);  // lw, no wait
`ifdef CU_ILLEGAL_TRAP_EN
        run_halt();
`else
        run(32'h0000007F, 0, -1, 4'h0, 3);  // illegal as NOP
`endif
        run(32'h0080A283, 5, 4, -1, -1);    // reset during MEM_L wait
        run(32'h402081B3, 0, -1, 4'h8, 3);

        ex_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
